// File: rtl/param_data_memory_if.sv
// Request/response bundle for the parametrised data memory.
// The master drives the access request; the slave returns read data and status flags.
interface param_data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [ADDR_W-1:0]     Address;
    logic [DATA_W-1:0]     WriteData;
    logic [DATA_W/8-1:0]   ByteEn;
    logic [DATA_W-1:0]     ReadData;
    logic                  ReadValid;
    logic                  AddrError;
    logic                  Busy;

    modport master (
        output MemRead, MemWrite, Address, WriteData, ByteEn,
        input  ReadData, ReadValid, AddrError, Busy
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData, ByteEn,
        output ReadData, ReadValid, AddrError, Busy
    );
endinterface

// File: rtl/param_data_memory.sv
// Byte-enabled data memory with a post-reset clear sweep; reads return one cycle later with ReadValid.
// No backpressure: requests are dropped while Busy, rejected accesses raise AddrError for one cycle.
module param_data_memory #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 128,
    parameter int ADDR_W         = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    param_data_memory_if.slave   bus
);
    localparam int          NBYTES  = DATA_W / 8;
    localparam int          OFF_W   = $clog2(NBYTES);
    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_U = DEPTH;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } stateT;

    stateT              state, stateNext;
    logic [IDX_W-1:0]   clearCnt, clearCntNext;
    logic               sweepWe;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  wordIdx;
    logic [IDX_W-1:0]   memIdx;
    logic               misaligned, outOfRange, addrOk;
    logic               req, doWrite, doRead, reject;
    logic [DATA_W-1:0]  oldWord, mergedWord;

    logic [DATA_W-1:0]  readDataQ;
    logic               readValidQ, addrErrorQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR_ON_RESET ? INIT : READY;
            clearCnt <= '0;
        end else begin
            state    <= stateNext;
            clearCnt <= clearCntNext;
        end
    end

    always_comb begin
        stateNext    = state;
        clearCntNext = clearCnt;
        sweepWe      = 1'b0;
        unique case (state)
            INIT: begin
                sweepWe = 1'b1;
                if (clearCnt == IDX_W'(DEPTH - 1)) begin
                    stateNext = READY;
                end else begin
                    clearCntNext = clearCnt + 1'b1;
                end
            end
            READY: begin
                stateNext = READY;
            end
            default: begin
                stateNext = READY;
            end
        endcase
    end

    // Unsigned index compare, so high address bits can never alias back into range.
    assign wordIdx    = bus.Address >> OFF_W;
    assign memIdx     = wordIdx[IDX_W-1:0];
    assign misaligned = |bus.Address[OFF_W-1:0];
    assign outOfRange = 32'(wordIdx) >= DEPTH_U;
    assign addrOk     = !misaligned && !outOfRange;

    assign req     = !reset && (state == READY) && (bus.MemRead || bus.MemWrite);
    assign doWrite = req && addrOk && bus.MemWrite;
    assign doRead  = req && addrOk && bus.MemRead;
    assign reject  = req && !addrOk;

    assign oldWord = mem[memIdx];

    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < NBYTES; i++) begin
            if (bus.ByteEn[i]) begin
                mergedWord[8*i +: 8] = bus.WriteData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sweepWe && !reset) begin
            mem[clearCnt] <= '0;
        end else if (doWrite) begin
            mem[memIdx] <= mergedWord;
        end
    end

    // Write-first: a simultaneous read of the written word sees the merged value.
    always_ff @(posedge clk) begin
        if (reset) begin
            readDataQ  <= '0;
            readValidQ <= 1'b0;
            addrErrorQ <= 1'b0;
        end else begin
            readValidQ <= doRead;
            addrErrorQ <= reject;
            if (doRead) begin
                readDataQ <= doWrite ? mergedWord : oldWord;
            end
        end
    end

    assign bus.ReadData  = readDataQ;
    assign bus.ReadValid = readValidQ;
    assign bus.AddrError = addrErrorQ;
    assign bus.Busy      = reset ? CLEAR_ON_RESET : (state == INIT);
endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench: clear-sweep timing, byte-enable writes, address errors, write-first reads, reset variants.
module tb_param_data_memory;
    logic clk = 1'b0;
    logic resetA = 1'b1;
    logic resetB = 1'b1;
    int   checksTotal = 0;
    int   checksPassed = 0;

    always #5 clk = ~clk;

    param_data_memory_if #(.DATA_W(16), .ADDR_W(16)) busA ();
    param_data_memory_if #(.DATA_W(16), .ADDR_W(16)) busB ();

    param_data_memory #(.DATA_W(16), .DEPTH(128), .ADDR_W(16), .CLEAR_ON_RESET(1'b1)) dutA (
        .clk   (clk),
        .reset (resetA),
        .bus   (busA)
    );

    param_data_memory #(.DATA_W(16), .DEPTH(128), .ADDR_W(16), .CLEAR_ON_RESET(1'b0)) dutB (
        .clk   (clk),
        .reset (resetB),
        .bus   (busB)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checksTotal++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end else begin
            checksPassed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accA(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be);
        busA.MemRead   = rd;
        busA.MemWrite  = wr;
        busA.Address   = addr;
        busA.WriteData = data;
        busA.ByteEn    = be;
        tick();
        busA.MemRead  = 1'b0;
        busA.MemWrite = 1'b0;
    endtask

    task automatic accB(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [1:0] be);
        busB.MemRead   = rd;
        busB.MemWrite  = wr;
        busB.Address   = addr;
        busB.WriteData = data;
        busB.ByteEn    = be;
        tick();
        busB.MemRead  = 1'b0;
        busB.MemWrite = 1'b0;
    endtask

    // Counts cycles with Busy high, bounded so a stuck sweep still ends the run.
    task automatic countBusy(output int n);
        n = 0;
        while (busA.Busy && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic sawValid, sawErr;

        busA.MemRead = 0; busA.MemWrite = 0; busA.Address = 0; busA.WriteData = 0; busA.ByteEn = 0;
        busB.MemRead = 0; busB.MemWrite = 0; busB.Address = 0; busB.WriteData = 0; busB.ByteEn = 0;

        // 1) reset and clear sweep
        tick();
        chk("rst_busy", 32'(busA.Busy), 1);
        chk("rst_rdata", 32'(busA.ReadData), 0);
        chk("rst_rvalid", 32'(busA.ReadValid), 0);
        chk("rst_aerr", 32'(busA.AddrError), 0);
        resetA = 1'b0;
        countBusy(n);
        chk("busy_len", 32'(n), 128);
        accA(1, 0, 16'd24, 16'h0, 2'b00);
        chk("rd12_data", 32'(busA.ReadData), 0);
        chk("rd12_valid", 32'(busA.ReadValid), 1);
        tick();
        chk("rvalid_one_cycle", 32'(busA.ReadValid), 0);

        // 2) full write then read
        accA(0, 1, 16'd30, 16'd200, 2'b11);
        chk("wr_valid", 32'(busA.ReadValid), 0);
        chk("wr_aerr", 32'(busA.AddrError), 0);
        accA(1, 0, 16'd30, 16'h0, 2'b00);
        chk("rd15_data", 32'(busA.ReadData), 200);
        chk("rd15_valid", 32'(busA.ReadValid), 1);

        // 3) byte enables
        accA(0, 1, 16'd30, 16'h1234, 2'b11);
        accA(0, 1, 16'd30, 16'hABCD, 2'b01);
        accA(1, 0, 16'd30, 16'h0, 2'b00);
        chk("be01", 32'(busA.ReadData), 32'h12CD);
        accA(0, 1, 16'd30, 16'hFFFF, 2'b00);
        chk("be00_aerr", 32'(busA.AddrError), 0);
        accA(1, 0, 16'd30, 16'h0, 2'b00);
        chk("be00", 32'(busA.ReadData), 32'h12CD);
        accA(0, 1, 16'd30, 16'h7700, 2'b10);
        accA(1, 0, 16'd30, 16'h0, 2'b00);
        chk("be10", 32'(busA.ReadData), 32'h77CD);

        // 4) address errors
        accA(1, 0, 16'd31, 16'h0, 2'b00);
        chk("mis_aerr", 32'(busA.AddrError), 1);
        chk("mis_valid", 32'(busA.ReadValid), 0);
        chk("mis_hold", 32'(busA.ReadData), 32'h77CD);
        accA(0, 1, 16'd31, 16'hFFFF, 2'b11);
        chk("mis_wr_aerr", 32'(busA.AddrError), 1);
        accA(1, 0, 16'd256, 16'h0, 2'b00);
        chk("oor_aerr", 32'(busA.AddrError), 1);
        chk("oor_valid", 32'(busA.ReadValid), 0);
        accA(0, 1, 16'd256, 16'hFFFF, 2'b11);
        chk("oor_wr_aerr", 32'(busA.AddrError), 1);
        tick();
        chk("aerr_one_cycle", 32'(busA.AddrError), 0);
        accA(1, 0, 16'd30, 16'h0, 2'b00);
        chk("no_write_on_err", 32'(busA.ReadData), 32'h77CD);
        accA(0, 1, 16'd254, 16'hC0DE, 2'b11);
        chk("last_aerr", 32'(busA.AddrError), 0);
        accA(1, 0, 16'd254, 16'h0, 2'b00);
        chk("last_word", 32'(busA.ReadData), 32'hC0DE);
        accA(1, 0, 16'hFFFE, 16'h0, 2'b00);
        chk("high_addr_aerr", 32'(busA.AddrError), 1);

        // 5) simultaneous read and write, write-first
        accA(1, 1, 16'd40, 16'h5A5A, 2'b11);
        chk("rw_data", 32'(busA.ReadData), 32'h5A5A);
        chk("rw_valid", 32'(busA.ReadValid), 1);
        accA(1, 1, 16'd40, 16'h00FF, 2'b01);
        chk("rw_merge", 32'(busA.ReadData), 32'h5AFF);

        // 6) reset in the middle of the sweep; requests during the sweep are ignored
        resetA = 1'b1;
        tick();
        resetA = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        chk("mid_init_busy", 32'(busA.Busy), 1);
        resetA = 1'b1;
        tick();
        chk("rst2_rdata", 32'(busA.ReadData), 0);
        resetA = 1'b0;
        busA.MemRead = 1; busA.MemWrite = 1; busA.Address = 16'd31;
        busA.WriteData = 16'hFFFF; busA.ByteEn = 2'b11;
        n = 0; sawValid = 0; sawErr = 0;
        while (busA.Busy && n < 300) begin
            busA.Address = n[0] ? 16'd31 : 16'd30;
            tick();
            n++;
            sawValid |= busA.ReadValid;
            sawErr   |= busA.AddrError;
        end
        busA.MemRead = 0; busA.MemWrite = 0;
        chk("restart_busy_len", 32'(n), 128);
        chk("init_no_valid", 32'(sawValid), 0);
        chk("init_no_aerr", 32'(sawErr), 0);
        accA(1, 0, 16'd30, 16'h0, 2'b00);
        chk("cleared15", 32'(busA.ReadData), 0);
        accA(1, 0, 16'd254, 16'h0, 2'b00);
        chk("cleared127", 32'(busA.ReadData), 0);

        // CLEAR_ON_RESET=0 instance keeps contents across reset
        chk("b_rst_busy", 32'(busB.Busy), 0);
        resetB = 1'b0;
        accB(0, 1, 16'd10, 16'hBEEF, 2'b11);
        chk("b_busy", 32'(busB.Busy), 0);
        resetB = 1'b1;
        tick();
        chk("b_rst2_busy", 32'(busB.Busy), 0);
        chk("b_rst2_rdata", 32'(busB.ReadData), 0);
        resetB = 1'b0;
        accB(1, 0, 16'd10, 16'h0, 2'b00);
        chk("b_kept", 32'(busB.ReadData), 32'hBEEF);
        chk("b_kept_valid", 32'(busB.ReadValid), 1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
